// File: rtl/dispatch_queue_if.sv
// Shared types and the Rename/backend-facing bundle of the dispatch queue.
// The package precedes the interface because both the interface and the queue use its types.
package dispatch_queue_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] FNC7_MULDIV   = 7'b0000001;

  // The enum value doubles as the issue-queue index.
  typedef enum logic [1:0] {
    CLS_ALU = 2'd0,
    CLS_LD  = 2'd1,
    CLS_ST  = 2'd2,
    CLS_MDU = 2'd3
  } rs_class_e;

  typedef struct packed {
    logic        is_valid;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic        has_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } instruction_t;

  typedef struct packed {
    logic        is_valid;
    logic        is_ready;
    logic        exception;
    logic [3:0]  exc_cause;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        has_rd;
    logic [6:0]  opcode;
  } rob_entry_t;

endpackage

interface dispatch_queue_if #(
  parameter int WIDTH  = 2,
  parameter int DEPTH  = 8,
  parameter int NUM_RS = 4,
  parameter int CW     = $clog2(WIDTH + 1)
);
  import dispatch_queue_pkg::*;

  localparam int OW = $clog2(DEPTH + 1);

  logic                               flush;
  logic                               dispatch_rdy;
  instruction_t [WIDTH-1:0]           renamed_insts;
  logic [NUM_RS-1:0][CW-1:0]          rs_free_cnt;
  logic [NUM_RS-1:0][WIDTH-1:0]       rs_wes;
  instruction_t [NUM_RS-1:0][WIDTH-1:0] rs_issue_ports;
  logic [CW-1:0]                      rob_free_cnt;
  logic [WIDTH-1:0]                   rob_we;
  rob_entry_t [WIDTH-1:0]             rob_entries;
  logic [OW-1:0]                      occupancy;

  modport master (
    output flush, renamed_insts, rs_free_cnt, rob_free_cnt,
    input  dispatch_rdy, rs_wes, rs_issue_ports, rob_we, rob_entries, occupancy
  );

  modport slave (
    input  flush, renamed_insts, rs_free_cnt, rob_free_cnt,
    output dispatch_rdy, rs_wes, rs_issue_ports, rob_we, rob_entries, occupancy
  );

endinterface

// File: rtl/dispatch_queue.sv
// Circular dispatch buffer between Rename and the issue queues/ROB.
// Optional stall counters are enabled with the DISPATCH_QUEUE_STATS_EN macro.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int DEPTH  = 8,
  parameter int NUM_RS = 4,
  parameter int CW     = $clog2(WIDTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  dispatch_queue_if.slave dq
`ifdef DISPATCH_QUEUE_STATS_EN
  ,
  output logic [31:0]    stall_rob_cycles,
  output logic [31:0]    stall_rs_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  instruction_t  mem     [DEPTH];
  rs_class_e     cls_mem [DEPTH];

  logic [AW-1:0] head, tail;
  logic [OW-1:0] occ;
  logic          accept;
  logic [OW-1:0] valid_count, enq_count, deq_count, avail;
  logic [AW-1:0] wr_idx  [WIDTH];
  logic [CW-1:0] cls_cnt [NUM_RS];
  logic [AW-1:0] rd_idx;
  logic          cls_ok;
  logic          blocked;

  function automatic rs_class_e classify(instruction_t inst);
    if (inst.opcode == OPC_LOAD)                                    return CLS_LD;
    if (inst.opcode == OPC_STORE)                                   return CLS_ST;
    if (inst.opcode == OPC_ARI_RTYPE && inst.funct7 == FNC7_MULDIV) return CLS_MDU;
    return CLS_ALU;
  endfunction

  function automatic rob_entry_t make_rob(instruction_t inst);
    rob_entry_t e;
    e          = '0;
    e.is_valid = 1'b1;
    e.pc       = inst.pc;
    e.rd       = inst.rd;
    e.has_rd   = inst.has_rd;
    e.opcode   = inst.opcode;
    return e;
  endfunction

  // No credit for a same-cycle dequeue: readiness depends on registered occupancy only.
  assign accept          = rst_n && !dq.flush && ((DEPTH - int'(occ)) >= WIDTH);
  assign dq.dispatch_rdy = accept;
  assign dq.occupancy    = occ;
  assign enq_count       = accept ? valid_count : '0;

  // Compaction: each valid slot lands at tail plus the number of valid slots before it.
  always_comb begin
    // NOTE: blocking assignments here build a running count within one evaluation.
    valid_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      wr_idx[i] = tail + AW'(valid_count);
      if (dq.renamed_insts[i].is_valid) valid_count = valid_count + OW'(1);
    end
  end

  // NOTE: storage has no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (dq.renamed_insts[i].is_valid) begin
          mem[wr_idx[i]]     <= dq.renamed_insts[i];
          cls_mem[wr_idx[i]] <= classify(dq.renamed_insts[i]);
        end
      end
    end
  end

  always_comb begin
    // NOTE: every output is defaulted first so no path through the loops infers a latch.
    dq.rob_we         = '0;
    dq.rob_entries    = '0;
    dq.rs_wes         = '0;
    dq.rs_issue_ports = '0;
    deq_count         = '0;
    blocked           = 1'b0;
    rd_idx            = head;
    cls_ok            = 1'b0;
    for (int r = 0; r < NUM_RS; r++) cls_cnt[r] = '0;
    avail = (int'(occ) < WIDTH) ? occ : OW'(WIDTH);

    for (int k = 0; k < WIDTH; k++) begin
      rd_idx = head + AW'(k);
      cls_ok = 1'b0;
      for (int r = 0; r < NUM_RS; r++)
        if (r == int'(cls_mem[rd_idx]) && cls_cnt[r] < dq.rs_free_cnt[r]) cls_ok = 1'b1;

      // The first candidate that fails either check stops the rest of the group.
      if (!blocked && k < int'(avail)) begin
        if (cls_ok && k < int'(dq.rob_free_cnt)) begin
          dq.rob_we[k]      = 1'b1;
          dq.rob_entries[k] = make_rob(mem[rd_idx]);
          for (int r = 0; r < NUM_RS; r++) begin
            if (r == int'(cls_mem[rd_idx])) begin
              for (int j = 0; j < WIDTH; j++) begin
                if (j == int'(cls_cnt[r])) begin
                  dq.rs_wes[r][j]         = 1'b1;
                  dq.rs_issue_ports[r][j] = mem[rd_idx];
                end
              end
              cls_cnt[r] = cls_cnt[r] + CW'(1);
            end
          end
          deq_count = deq_count + OW'(1);
        end else begin
          blocked = 1'b1;
        end
      end
    end

    if (!rst_n || dq.flush) begin
      dq.rob_we         = '0;
      dq.rob_entries    = '0;
      dq.rs_wes         = '0;
      dq.rs_issue_ports = '0;
      deq_count         = '0;
      blocked           = 1'b0;
    end
  end

  // Flush shares the synchronous clear path with reset; held entries are simply abandoned.
  always_ff @(posedge clk) begin
    if (!rst_n || dq.flush) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      head <= head + AW'(deq_count);
      tail <= tail + AW'(enq_count);
      occ  <= occ + enq_count - deq_count;
    end
  end

`ifdef DISPATCH_QUEUE_STATS_EN
  // The first blocked candidate sits at index deq_count, so its ROB check is that index vs the credit.
  logic block_rob;
  assign block_rob = int'(deq_count) >= int'(dq.rob_free_cnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_rob_cycles <= '0;
      stall_rs_cycles  <= '0;
    end else if (blocked) begin
      if (block_rob) begin
        if (stall_rob_cycles != '1) stall_rob_cycles <= stall_rob_cycles + 32'd1;
      end else begin
        if (stall_rs_cycles != '1) stall_rs_cycles <= stall_rs_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// Scoreboard bench for dispatch_queue (WIDTH=2, DEPTH=8): stimulus pushes expected dispatches,
// a negedge monitor pops and compares whatever the DUT writes to the ROB and issue queues.
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int WIDTH  = 2;
  localparam int DEPTH  = 8;
  localparam int NUM_RS = 4;

  typedef struct {
    instruction_t inst;
    rs_class_e    cls;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dispatch_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RS(NUM_RS)) dq ();

`ifdef DISPATCH_QUEUE_STATS_EN
  logic [31:0] stall_rob_cycles, stall_rs_cycles;
  logic [31:0] cap_rob, cap_rs;
`endif

  dispatch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RS(NUM_RS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dq    (dq)
`ifdef DISPATCH_QUEUE_STATS_EN
    ,
    .stall_rob_cycles (stall_rob_cycles),
    .stall_rs_cycles  (stall_rs_cycles)
`endif
  );

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  instruction_t bubble;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic instruction_t mk(logic [31:0] pc, logic [6:0] opc, logic [6:0] f7);
    instruction_t i;
    i          = '0;
    i.is_valid = 1'b1;
    i.pc       = pc;
    i.opcode   = opc;
    i.funct7   = f7;
    i.funct3   = 3'd2;
    i.rd       = pc[6:2];
    i.has_rd   = (opc != OPC_STORE);
    i.rs1      = 5'd1;
    i.rs2      = 5'd2;
    i.imm      = pc ^ 32'h0000_5a5a;
    return i;
  endfunction

  function automatic instruction_t add_i(logic [31:0] pc); return mk(pc, OPC_ARI_RTYPE, 7'd0);       endfunction
  function automatic instruction_t mul_i(logic [31:0] pc); return mk(pc, OPC_ARI_RTYPE, FNC7_MULDIV); endfunction
  function automatic instruction_t lw_i (logic [31:0] pc); return mk(pc, OPC_LOAD, FNC7_MULDIV);      endfunction
  function automatic instruction_t sw_i (logic [31:0] pc); return mk(pc, OPC_STORE, 7'd0);            endfunction

  function automatic rob_entry_t to_rob(instruction_t i);
    rob_entry_t r;
    r          = '0;
    r.is_valid = 1'b1;
    r.pc       = i.pc;
    r.rd       = i.rd;
    r.has_rd   = i.has_rd;
    r.opcode   = i.opcode;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic put(input instruction_t a, input rs_class_e ca,
                     input instruction_t b, input rs_class_e cb, input bit acc);
    dq.renamed_insts[0] = a;
    dq.renamed_insts[1] = b;
    #1;
    check("dispatch_rdy", dq.dispatch_rdy, acc);
    if (acc) begin
      if (a.is_valid) sb.push_back(exp_t'{inst: a, cls: ca});
      if (b.is_valid) sb.push_back(exp_t'{inst: b, cls: cb});
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] rob_we,
                            input logic [7:0] rs_wes, input int occ);
    check({tag, ".rob_we"},    dq.rob_we, rob_we);
    check({tag, ".rs_wes"},    dq.rs_wes, rs_wes);
    check({tag, ".occupancy"}, dq.occupancy, occ);
  endtask

  task automatic set_free(input logic [1:0] alu, input logic [1:0] ld, input logic [1:0] st,
                          input logic [1:0] mdu, input logic [1:0] rob);
    dq.rs_free_cnt[0] = alu;
    dq.rs_free_cnt[1] = ld;
    dq.rs_free_cnt[2] = st;
    dq.rs_free_cnt[3] = mdu;
    dq.rob_free_cnt   = rob;
  endtask

  // Monitor: every ROB write must be the next expected instruction, routed to its class queue.
  always @(negedge clk) begin
    int   used [NUM_RS];
    bit   gap;
    exp_t e;
    for (int r = 0; r < NUM_RS; r++) used[r] = 0;
    gap = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (dq.rob_we[k]) begin
        check("rob_we_contiguous", gap, 1'b0);
        check("dispatch_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rob_entry", dq.rob_entries[k], to_rob(e.inst));
          for (int r = 0; r < NUM_RS; r++) begin
            if (r == int'(e.cls) && used[r] < WIDTH) begin
              check("rs_port", dq.rs_issue_ports[r][used[r]], e.inst);
              used[r]++;
            end
          end
        end
      end else begin
        gap = 1'b1;
        check("rob_idle_zero", dq.rob_entries[k], '0);
      end
    end
    for (int r = 0; r < NUM_RS; r++) begin
      check("rs_wes_mask", dq.rs_wes[r], (1 << used[r]) - 1);
      for (int j = 0; j < WIDTH; j++)
        if (j >= used[r]) check("rs_idle_zero", dq.rs_issue_ports[r][j], '0);
    end
  end

  initial begin
    int          budget;
    logic [31:0] pc;
    bubble           = '0;
    dq.flush         = 1'b0;
    dq.renamed_insts = '0;
    set_free(2'd2, 2'd2, 2'd2, 2'd2, 2'd2);

    // Reset for two cycles with a valid group presented; nothing may be accepted.
    dq.renamed_insts[0] = add_i(32'hdead_0000);
    tick();
    tick();
    check("reset.dispatch_rdy", dq.dispatch_rdy, 1'b0);
    expect_out("reset", 2'b00, 8'h00, 0);
    rst_n            = 1'b1;
    dq.renamed_insts = '0;
    settle();
    check("post_reset.dispatch_rdy", dq.dispatch_rdy, 1'b1);
    expect_out("post_reset", 2'b00, 8'h00, 0);
`ifdef DISPATCH_QUEUE_STATS_EN
    check("post_reset.stall_rob", stall_rob_cycles, 32'd0);
    check("post_reset.stall_rs",  stall_rs_cycles,  32'd0);
`endif

    // {ADD,LW} into an empty queue, everything free: both go out next cycle.
    put(add_i(32'h100), CLS_ALU, lw_i(32'h104), CLS_LD, 1'b1);
    tick(); dq.renamed_insts = '0; settle();
    expect_out("t1", 2'b11, 8'b00_00_01_01, 2);
    tick();
    expect_out("t1_done", 2'b00, 8'h00, 0);

    // {MUL,MUL} with one MDU slot: one per cycle.
    set_free(2'd2, 2'd2, 2'd2, 2'd1, 2'd2);
    put(mul_i(32'h200), CLS_MDU, mul_i(32'h204), CLS_MDU, 1'b1);
    tick(); dq.renamed_insts = '0; settle();
    expect_out("t2a", 2'b01, 8'b01_00_00_00, 2);
    tick();
    expect_out("t2b", 2'b01, 8'b01_00_00_00, 1);
    tick();
    expect_out("t2c", 2'b00, 8'h00, 0);

    // {ADD,SW} with one ROB slot: only ADD; the stall is charged to the ROB.
    set_free(2'd2, 2'd2, 2'd2, 2'd2, 2'd1);
    put(add_i(32'h300), CLS_ALU, sw_i(32'h304), CLS_ST, 1'b1);
    tick(); dq.renamed_insts = '0; settle();
    expect_out("t3a", 2'b01, 8'b00_00_00_01, 2);
`ifdef DISPATCH_QUEUE_STATS_EN
    cap_rob = stall_rob_cycles; cap_rs = stall_rs_cycles;
`endif
    tick();
`ifdef DISPATCH_QUEUE_STATS_EN
    check("t3a.stall_rob", stall_rob_cycles, cap_rob + 32'd1);
    check("t3a.stall_rs",  stall_rs_cycles,  cap_rs);
`endif
    dq.rob_free_cnt = 2'd2; settle();
    expect_out("t3b", 2'b01, 8'b00_01_00_00, 1);
    tick();

    // {LW,ADD} with no LD slot: strict order holds ADD back too.
    set_free(2'd2, 2'd0, 2'd2, 2'd2, 2'd2);
    put(lw_i(32'h400), CLS_LD, add_i(32'h404), CLS_ALU, 1'b1);
    tick(); dq.renamed_insts = '0; settle();
    expect_out("t3c", 2'b00, 8'h00, 2);
`ifdef DISPATCH_QUEUE_STATS_EN
    cap_rob = stall_rob_cycles; cap_rs = stall_rs_cycles;
`endif
    tick();
`ifdef DISPATCH_QUEUE_STATS_EN
    check("t3c.stall_rob", stall_rob_cycles, cap_rob);
    check("t3c.stall_rs",  stall_rs_cycles,  cap_rs + 32'd1);
`endif
    dq.rs_free_cnt[1] = 2'd2; settle();
    expect_out("t3d", 2'b11, 8'b00_00_01_01, 2);
    tick();

    // Two ALU ops pack onto ports 0,1; a compacted group enqueues alongside a dequeue.
    put(add_i(32'h500), CLS_ALU, add_i(32'h504), CLS_ALU, 1'b1);
    tick(); settle();
    expect_out("t3e", 2'b11, 8'b00_00_00_11, 2);
    put(bubble, CLS_ALU, mul_i(32'h508), CLS_MDU, 1'b1);
    tick(); dq.renamed_insts = '0; settle();
    expect_out("t3f", 2'b01, 8'b01_00_00_00, 1);
    tick();
    expect_out("t3g", 2'b00, 8'h00, 0);
    put(bubble, CLS_ALU, bubble, CLS_ALU, 1'b1);
    tick(); settle();
    expect_out("t3h", 2'b00, 8'h00, 0);

    // Fill to 7 with no credits, then drain 20 sequential PCs through the wrapping buffer.
    set_free(2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    put(add_i(32'h1000), CLS_ALU, lw_i(32'h1004), CLS_LD, 1'b1); tick();
    put(add_i(32'h1008), CLS_ALU, lw_i(32'h100c), CLS_LD, 1'b1); tick();
    put(add_i(32'h1010), CLS_ALU, lw_i(32'h1014), CLS_LD, 1'b1); tick();
    put(bubble, CLS_ALU, add_i(32'h1018), CLS_ALU, 1'b1); tick();
    dq.renamed_insts = '0; settle();
    expect_out("t4a", 2'b00, 8'h00, 7);
    put(add_i(32'h101c), CLS_ALU, lw_i(32'h1020), CLS_LD, 1'b0);
    set_free(2'd2, 2'd2, 2'd2, 2'd2, 2'd2); settle();
    expect_out("t4b", 2'b11, 8'b00_00_01_01, 7);
    check("t4b.dispatch_rdy", dq.dispatch_rdy, 1'b0);
    tick();
    check("t4c.occupancy", dq.occupancy, 5);
    put(add_i(32'h101c), CLS_ALU, lw_i(32'h1020), CLS_LD, 1'b1);
    pc = 32'h1024;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4d.occupancy", dq.occupancy, 5);
      put(add_i(pc), CLS_ALU, lw_i(pc + 32'd4), CLS_LD, 1'b1);
      pc = pc + 32'd8;
    end
    tick();
    put(add_i(32'h104c), CLS_ALU, bubble, CLS_ALU, 1'b1);
    tick(); dq.renamed_insts = '0; settle();
    check("t4e.occupancy", dq.occupancy, 4);
    budget = 0;
    while (budget < 20 && dq.occupancy != 0) begin
      tick();
      budget++;
    end
    check("t4f.drained", dq.occupancy, 0);
    check("t4f.scoreboard_empty", sb.size(), 0);

    // Flush at occupancy 5 while Rename presents a group.
    set_free(2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    put(add_i(32'h2000), CLS_ALU, lw_i(32'h2004), CLS_LD, 1'b1); tick();
    put(add_i(32'h2008), CLS_ALU, lw_i(32'h200c), CLS_LD, 1'b1); tick();
    put(bubble, CLS_ALU, mul_i(32'h2010), CLS_MDU, 1'b1); tick();
    dq.renamed_insts = '0; settle();
    expect_out("t5a", 2'b00, 8'h00, 5);
    dq.flush            = 1'b1;
    dq.renamed_insts[0] = add_i(32'h2014);
    dq.renamed_insts[1] = add_i(32'h2018);
    set_free(2'd2, 2'd2, 2'd2, 2'd2, 2'd2); settle();
    expect_out("t5b", 2'b00, 8'h00, 5);
    check("t5b.dispatch_rdy", dq.dispatch_rdy, 1'b0);
    check("t5b.held", sb.size(), 5);
    tick();
    dq.flush         = 1'b0;
    dq.renamed_insts = '0;
    sb.delete();
    settle();
    expect_out("t5c", 2'b00, 8'h00, 0);
    put(add_i(32'h3000), CLS_ALU, sw_i(32'h3004), CLS_ST, 1'b1);
    tick(); dq.renamed_insts = '0; settle();
    expect_out("t5d", 2'b11, 8'b00_01_00_01, 2);
    tick();
    expect_out("t5e", 2'b00, 8'h00, 0);
    check("final.scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
